// File: rtl/axi_lite_master.sv
// rtl/axi_lite_master.sv - single-outstanding AXI4-Lite master driven by a cmd/rsp handshake
module axi_lite_master #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   // command side
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   input  logic [3:0]            cmd_wstrb,
   // response side
   output logic                  rsp_valid,
   output logic                  rsp_write,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic [1:0]            rsp_resp,
   output logic [7:0]            err_count,
   // AXI4-Lite write address channel
   output logic [ADDR_WIDTH-1:0] awaddr,
   output logic                  awvalid,
   input  logic                  awready,
   // AXI4-Lite write data channel
   output logic [DATA_WIDTH-1:0] wdata,
   output logic [3:0]            wstrb,
   output logic                  wvalid,
   input  logic                  wready,
   // AXI4-Lite write response channel
   input  logic [1:0]            bresp,
   input  logic                  bvalid,
   output logic                  bready,
   // AXI4-Lite read address channel
   output logic [ADDR_WIDTH-1:0] araddr,
   output logic                  arvalid,
   input  logic                  arready,
   // AXI4-Lite read data channel
   input  logic [DATA_WIDTH-1:0] rdata,
   input  logic [1:0]            rresp,
   input  logic                  rvalid,
   output logic                  rready
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR,
      S_WR_RESP,
      S_RD_ADDR,
      S_RD_DATA,
      S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic                  write_q, write_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [3:0]            wstrb_q, wstrb_d;
   logic                  awvalid_q, awvalid_d;
   logic                  wvalid_q, wvalid_d;
   logic                  arvalid_q, arvalid_d;
   logic                  aw_done_q, aw_done_d;
   logic                  w_done_q, w_done_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [1:0]            rsp_resp_q, rsp_resp_d;
   logic [7:0]            err_count_q, err_count_d;

   // State and datapath registers; reset abandons any transaction in flight
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q     <= S_IDLE;
         write_q     <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= '0;
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         write_q     <= write_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         arvalid_q   <= arvalid_d;
         aw_done_q   <= aw_done_d;
         w_done_q    <= w_done_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_resp_q  <= rsp_resp_d;
         err_count_q <= err_count_d;
      end
   end

   // Next-state logic; every VALID is a flop so it never follows READY combinationally
   always_comb begin
      state_d     = state_q;
      write_d     = write_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      arvalid_d   = arvalid_q;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_resp_d  = rsp_resp_q;
      err_count_d = err_count_q;

      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               write_d = cmd_write;
               addr_d  = cmd_addr;
               wdata_d = cmd_wdata;
               wstrb_d = cmd_wstrb;
               if (cmd_write) begin
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  aw_done_d = 1'b0;
                  w_done_d  = 1'b0;
                  state_d   = S_WR;
               end else begin
                  arvalid_d = 1'b1;
                  state_d   = S_RD_ADDR;
               end
            end
         end
         S_WR: begin
            // AW and W complete independently, in any order or together
            if (awvalid_q && awready) begin
               awvalid_d = 1'b0;
               aw_done_d = 1'b1;
            end
            if (wvalid_q && wready) begin
               wvalid_d = 1'b0;
               w_done_d = 1'b1;
            end
            if (aw_done_d && w_done_d) begin
               state_d = S_WR_RESP;
            end
         end
         S_WR_RESP: begin
            if (bvalid) begin
               rsp_resp_d = bresp;
               state_d    = S_DONE;
            end
         end
         S_RD_ADDR: begin
            if (arvalid_q && arready) begin
               arvalid_d = 1'b0;
               state_d   = S_RD_DATA;
            end
         end
         S_RD_DATA: begin
            if (rvalid) begin
               rsp_rdata_d = rdata;
               rsp_resp_d  = rresp;
               state_d     = S_DONE;
            end
         end
         S_DONE: begin
            if (rsp_resp_q != 2'b00 && err_count_q != 8'hFF) begin
               err_count_d = err_count_q + 8'd1;
            end
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign cmd_ready = (state_q == S_IDLE);
   assign rsp_valid = (state_q == S_DONE);
   assign rsp_write = write_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_resp  = rsp_resp_q;
   assign err_count = err_count_q;

   assign awaddr  = addr_q;
   assign awvalid = awvalid_q;
   assign wdata   = wdata_q;
   assign wstrb   = wstrb_q;
   assign wvalid  = wvalid_q;
   assign bready  = (state_q == S_WR_RESP);
   assign araddr  = addr_q;
   assign arvalid = arvalid_q;
   assign rready  = (state_q == S_RD_DATA);

endmodule

// File: tb/tb_axi_lite_master.sv
// tb/tb_axi_lite_master.sv - self-checking bench for axi_lite_master with a scripted AXI-Lite slave
module tb_axi_lite_master;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_write = 1'b0;
   logic [31:0] cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic [3:0]  cmd_wstrb = '0;
   logic        rsp_valid;
   logic        rsp_write;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [7:0]  err_count;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready = 1'b0;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready = 1'b0;
   logic [1:0]  bresp = '0;
   logic        bvalid = 1'b0;
   logic        bready;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready = 1'b0;
   logic [31:0] rdata = '0;
   logic [1:0]  rresp = '0;
   logic        rvalid = 1'b0;
   logic        rready;

   int checks = 0;
   int errors = 0;

   // reference model state
   int          exp_err = 0;
   int          exp_rsp = 0;
   int          exp_aw = 0, exp_w = 0, exp_b = 0, exp_ar = 0, exp_r = 0;
   logic [31:0] exp_rdata = '0;
   logic [1:0]  exp_resp = '0;

   // monitor counters
   int          aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0, rsp_cnt = 0;
   int          ar_run = 0, ar_last = 0;
   logic        p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
   logic [31:0] p_awaddr = '0, p_wdata = '0, p_araddr = '0;
   logic [3:0]  p_wstrb = '0;

   axi_lite_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
      .rsp_resp(rsp_resp), .err_count(err_count),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
   );

   always #5 aclk = ~aclk;

   // Protocol monitor: VALID/payload stability, post-handshake drop, handshake counting
   always @(negedge aclk) begin
      if (!aresetn) begin
         p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0;
         ar_run = 0;
      end else begin
         if (p_awv && !p_awr) begin
            checks++;
            if (awvalid !== 1'b1 || awaddr !== p_awaddr) begin
               errors++;
               $display("FAIL aw_stable: awvalid=%b awaddr=%h, required 1/%h", awvalid, awaddr, p_awaddr);
            end
         end
         if (p_awv && p_awr) begin
            checks++;
            if (awvalid !== 1'b0) begin
               errors++;
               $display("FAIL aw_drop: awvalid=%b, required 0", awvalid);
            end
         end
         if (p_wv && !p_wr) begin
            checks++;
            if (wvalid !== 1'b1 || wdata !== p_wdata || wstrb !== p_wstrb) begin
               errors++;
               $display("FAIL w_stable: wvalid=%b wdata=%h wstrb=%h, required 1/%h/%h",
                        wvalid, wdata, wstrb, p_wdata, p_wstrb);
            end
         end
         if (p_wv && p_wr) begin
            checks++;
            if (wvalid !== 1'b0) begin
               errors++;
               $display("FAIL w_drop: wvalid=%b, required 0", wvalid);
            end
         end
         if (p_arv && !p_arr) begin
            checks++;
            if (arvalid !== 1'b1 || araddr !== p_araddr) begin
               errors++;
               $display("FAIL ar_stable: arvalid=%b araddr=%h, required 1/%h", arvalid, araddr, p_araddr);
            end
         end
         if (p_arv && p_arr) begin
            checks++;
            if (arvalid !== 1'b0) begin
               errors++;
               $display("FAIL ar_drop: arvalid=%b, required 0", arvalid);
            end
         end
         if (awvalid && awready) aw_hs++;
         if (wvalid && wready) w_hs++;
         if (bvalid && bready) b_hs++;
         if (arvalid && arready) ar_hs++;
         if (rvalid && rready) r_hs++;
         if (rsp_valid) rsp_cnt++;
         if (arvalid) ar_run++;
         else if (ar_run != 0) begin
            ar_last = ar_run;
            ar_run = 0;
         end
         p_awv = awvalid; p_awr = awready; p_awaddr = awaddr;
         p_wv = wvalid; p_wr = wready; p_wdata = wdata; p_wstrb = wstrb;
         p_arv = arvalid; p_arr = arready; p_araddr = araddr;
      end
   end

   // One complete transaction: d1/d2/d3 = AW/W/B delays for writes, AR/R delays for reads
   task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int d1, input int d2, input int d3,
                         input logic [1:0] resp);
      int guard;
      @(negedge aclk);
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL cmd_ready_idle: got %b, required 1", cmd_ready);
      end
      @(posedge aclk); #1;
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
      @(posedge aclk); #1;
      // keep cmd_valid high with different fields: must be ignored while busy
      cmd_write = ~wr; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
      if (wr) begin
         fork
            begin
               repeat (d1) begin @(posedge aclk); #1; end
               awready = 1'b1;
               @(negedge aclk);
               checks++;
               if (awvalid !== 1'b1 || awaddr !== addr) begin
                  errors++;
                  $display("FAIL aw_payload: awvalid=%b awaddr=%h, required 1/%h", awvalid, awaddr, addr);
               end
               @(posedge aclk); #1;
               awready = 1'b0;
            end
            begin
               repeat (d2) begin @(posedge aclk); #1; end
               wready = 1'b1;
               @(negedge aclk);
               checks++;
               if (wvalid !== 1'b1 || wdata !== data || wstrb !== strb) begin
                  errors++;
                  $display("FAIL w_payload: wvalid=%b wdata=%h wstrb=%h, required 1/%h/%h",
                           wvalid, wdata, wstrb, data, strb);
               end
               @(posedge aclk); #1;
               wready = 1'b0;
            end
         join
         repeat (d3) begin @(posedge aclk); #1; end
         bvalid = 1'b1; bresp = resp;
         @(negedge aclk);
         checks++;
         if (bready !== 1'b1 || awvalid !== 1'b0 || wvalid !== 1'b0 || rready !== 1'b0) begin
            errors++;
            $display("FAIL b_phase: bready=%b awvalid=%b wvalid=%b rready=%b, required 1/0/0/0",
                     bready, awvalid, wvalid, rready);
         end
         @(posedge aclk); #1;
         bvalid = 1'b0; bresp = 2'($urandom);
         exp_aw++; exp_w++; exp_b++;
      end else begin
         repeat (d1) begin @(posedge aclk); #1; end
         arready = 1'b1;
         @(negedge aclk);
         checks++;
         if (arvalid !== 1'b1 || araddr !== addr || rready !== 1'b0) begin
            errors++;
            $display("FAIL ar_payload: arvalid=%b araddr=%h rready=%b, required 1/%h/0",
                     arvalid, araddr, rready, addr);
         end
         @(posedge aclk); #1;
         arready = 1'b0;
         repeat (d2) begin @(posedge aclk); #1; end
         rvalid = 1'b1; rdata = data; rresp = resp;
         @(negedge aclk);
         checks++;
         if (rready !== 1'b1 || arvalid !== 1'b0 || bready !== 1'b0) begin
            errors++;
            $display("FAIL r_phase: rready=%b arvalid=%b bready=%b, required 1/0/0", rready, arvalid, bready);
         end
         @(posedge aclk); #1;
         rvalid = 1'b0; rdata = $urandom; rresp = 2'($urandom);
         exp_ar++; exp_r++;
         exp_rdata = data;
      end
      cmd_valid = 1'b0;
      exp_resp = resp;
      exp_rsp++;
      if (resp != 2'b00 && exp_err < 255) exp_err++;
      guard = 0;
      @(negedge aclk);
      while (rsp_valid !== 1'b1 && guard < 16) begin
         @(negedge aclk);
         guard++;
      end
      checks++;
      if (rsp_valid !== 1'b1 || rsp_write !== wr || rsp_resp !== exp_resp || rsp_rdata !== exp_rdata) begin
         errors++;
         $display("FAIL rsp: valid=%b write=%b resp=%b rdata=%h, required 1/%b/%b/%h",
                  rsp_valid, rsp_write, rsp_resp, rsp_rdata, wr, exp_resp, exp_rdata);
      end
      @(negedge aclk);
      checks++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || err_count !== 8'(exp_err)) begin
         errors++;
         $display("FAIL done_to_idle: rsp_valid=%b cmd_ready=%b err_count=%0d, required 0/1/%0d",
                  rsp_valid, cmd_ready, err_count, exp_err);
      end
      checks++;
      if (rsp_cnt != exp_rsp || aw_hs != exp_aw || w_hs != exp_w || b_hs != exp_b ||
          ar_hs != exp_ar || r_hs != exp_r) begin
         errors++;
         $display("FAIL hs_counts: rsp/aw/w/b/ar/r=%0d/%0d/%0d/%0d/%0d/%0d, required %0d/%0d/%0d/%0d/%0d/%0d",
                  rsp_cnt, aw_hs, w_hs, b_hs, ar_hs, r_hs, exp_rsp, exp_aw, exp_w, exp_b, exp_ar, exp_r);
      end
   endtask

   task automatic test_reset;
      aresetn = 1'b0;
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      checks++;
      if (cmd_ready !== 1'b1 || awvalid !== 1'b0 || wvalid !== 1'b0 || arvalid !== 1'b0 ||
          rready !== 1'b0 || bready !== 1'b0 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: cmd_ready=%b aw=%b w=%b ar=%b r=%b b=%b rsp=%b, required 1/0/0/0/0/0/0",
                  cmd_ready, awvalid, wvalid, arvalid, rready, bready, rsp_valid);
      end
      checks++;
      if (awaddr !== '0 || araddr !== '0 || wdata !== '0 || wstrb !== '0 ||
          rsp_rdata !== '0 || rsp_resp !== '0 || err_count !== '0) begin
         errors++;
         $display("FAIL reset_data: awaddr=%h araddr=%h wdata=%h wstrb=%h rdata=%h resp=%b err=%0d, required zeros",
                  awaddr, araddr, wdata, wstrb, rsp_rdata, rsp_resp, err_count);
      end
      @(posedge aclk); #3;
      aresetn = 1'b1;
      @(negedge aclk);
      checks++;
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: cmd_ready=%b rsp_valid=%b, required 1/0", cmd_ready, rsp_valid);
      end
   endtask

   task automatic test_write_zero_wait;
      do_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00);
   endtask

   task automatic test_read_delayed;
      do_txn(1'b0, 32'h10, 32'hDEADBEEF, 4'h0, 2, 2, 0, 2'b00);
      checks++;
      if (ar_last != 3) begin
         errors++;
         $display("FAIL arvalid_len: held %0d cycles, required 3", ar_last);
      end
   endtask

   task automatic test_skewed_write;
      do_txn(1'b1, 32'h24, 32'h1234_5678, 4'h5, 0, 4, 1, 2'b00);
      do_txn(1'b1, 32'h28, 32'hA5A5_0F0F, 4'hA, 3, 0, 0, 2'b00);
   endtask

   task automatic test_errors;
      for (int i = 0; i < 3; i++) do_txn(1'b0, 32'h100 + 32'(i * 4), $urandom, 4'h0, 0, 1, 0, 2'b10);
      do_txn(1'b1, 32'h200, 32'hCAFE_F00D, 4'hF, 1, 0, 0, 2'b11);
      checks++;
      if (err_count !== 8'd4) begin
         errors++;
         $display("FAIL err_count_4: got %0d, required 4", err_count);
      end
   endtask

   task automatic test_random;
      for (int i = 0; i < 40; i++) begin
         do_txn(1'($urandom), $urandom, $urandom, 4'($urandom),
                int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                2'($urandom));
      end
   endtask

   task automatic test_saturation;
      while (exp_err < 255) do_txn(1'b0, 32'h300, $urandom, 4'h0, 0, 0, 0, 2'b10);
      checks++;
      if (err_count !== 8'hFF) begin
         errors++;
         $display("FAIL err_sat_reach: got %0d, required 255", err_count);
      end
      do_txn(1'b1, 32'h304, $urandom, 4'hF, 0, 0, 0, 2'b10);
      do_txn(1'b0, 32'h308, $urandom, 4'h0, 0, 0, 0, 2'b11);
      checks++;
      if (err_count !== 8'hFF) begin
         errors++;
         $display("FAIL err_sat_hold: got %0d, required 255", err_count);
      end
   endtask

   task automatic test_reset_mid_txn;
      int base;
      @(negedge aclk);
      @(posedge aclk); #1;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h40; cmd_wdata = 32'h0BAD_BEEF; cmd_wstrb = 4'h3;
      @(posedge aclk); #1;
      cmd_valid = 1'b0; awready = 1'b1; wready = 1'b1;
      @(posedge aclk); #1;
      awready = 1'b0; wready = 1'b0;
      exp_aw++; exp_w++;
      @(negedge aclk);
      checks++;
      if (bready !== 1'b1) begin
         errors++;
         $display("FAIL mid_in_wr_resp: bready=%b, required 1", bready);
      end
      base = rsp_cnt;
      @(posedge aclk); #2;
      aresetn = 1'b0;
      #1;
      checks++;
      if (awvalid !== 1'b0 || wvalid !== 1'b0 || arvalid !== 1'b0 || rready !== 1'b0 ||
          bready !== 1'b0 || rsp_valid !== 1'b0 || err_count !== 8'd0) begin
         errors++;
         $display("FAIL mid_reset_async: aw=%b w=%b ar=%b r=%b b=%b rsp=%b err=%0d, required all 0",
                  awvalid, wvalid, arvalid, rready, bready, rsp_valid, err_count);
      end
      bvalid = 1'b1; bresp = 2'b00;
      repeat (2) @(posedge aclk);
      #3;
      bvalid = 1'b0;
      aresetn = 1'b1;
      exp_err = 0; exp_rdata = '0; exp_resp = '0;
      @(negedge aclk);
      checks++;
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== '0) begin
         errors++;
         $display("FAIL mid_release: cmd_ready=%b rsp_valid=%b rdata=%h, required 1/0/0",
                  cmd_ready, rsp_valid, rsp_rdata);
      end
      repeat (3) @(negedge aclk);
      checks++;
      if (rsp_cnt != base) begin
         errors++;
         $display("FAIL mid_no_rsp: rsp pulses %0d, required %0d", rsp_cnt, base);
      end
      do_txn(1'b0, 32'h44, 32'h7777_1111, 4'h0, 1, 1, 0, 2'b01);
   endtask

   initial begin
      test_reset();
      test_write_zero_wait();
      test_read_delayed();
      test_skewed_write();
      test_errors();
      test_random();
      test_saturation();
      test_reset_mid_txn();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
